// File: rtl/bm13xx_pkg.sv
// Shared definitions for the BM13xx work path.
// Holds the midstate code type, the work record geometry and the helper
// that turns a midstate code into a work length in 32-bit words.
package bm13xx_pkg;

    typedef enum logic [1:0] {
        MS_1    = 2'd0,
        MS_2    = 2'd1,
        MS_4    = 2'd2,
        MS_RSVD = 2'd3
    } midstate_code_t;

    localparam int WORK_HDR_WORDS = 4;
    localparam int MIDSTATE_WORDS = 8;
    // Wide enough for the longest record (36 words).
    localparam int WORK_LEN_W     = 6;

    // Record length = header + 8 words per midstate. The reserved code
    // behaves as a single midstate; codes beyond max_ms clamp to max_ms.
    function automatic logic [WORK_LEN_W-1:0] work_len(input midstate_code_t code,
                                                       input int max_ms);
        int ms;
        case (code)
            MS_2:    ms = 2;
            MS_4:    ms = 4;
            default: ms = 1;
        endcase
        if (ms > max_ms) ms = max_ms;
        return WORK_LEN_W'(WORK_HDR_WORDS + MIDSTATE_WORDS * ms);
    endfunction

endpackage

// File: rtl/bm13xx_sync_fifo.sv
// Generic single-clock show-ahead FIFO.
// The RAM is read synchronously straight into the output register, so a
// word fetched in cycle N is presented in cycle N+1. fetch_en lets the
// owner hold words back in the RAM (used for store-and-forward framing).
// The owner must not write while the RAM already holds DEPTH words.
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous flush (pointers, RAM count, output register)
//   wr_en/wr_data  push one entry
//   fetch_en       permit moving the RAM head into the output register
//   fetch          a RAM entry moves to the output register this cycle
//   rd_valid/rd_ready/rd_data  output register handshake
module bm13xx_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fetch_en,
    output logic             fetch,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    ram_cnt;

    // Refill the output register when it is empty or being drained.
    assign fetch = !clr && fetch_en && (ram_cnt != '0) && (!rd_valid || rd_ready);

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (fetch) begin
                rd_data  <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
            ram_cnt <= ram_cnt + CW'(wr_en) - CW'(fetch);
        end
    end

endmodule

// File: rtl/bm13xx_work_tx_buf.sv
// Store-and-forward work transmit buffer.
// Frames incoming 32-bit words into work records whose length follows the
// midstate code sampled on word 0, and only releases a record to the
// serialiser once its last word is stored. Tracks word/work occupancy,
// raises a free-space IRQ and captures the ID of the last popped work.
//   clk, rst_n             clock, asynchronous active-low reset
//   fifo_clr               synchronous flush, wins over same-cycle traffic
//   midstate_cfg           midstate code for the next work
//   irq_en, irq_thr        IRQ enable and free-space threshold (words)
//   wr_valid/wr_ready/wr_data          word input
//   rd_valid/rd_ready/rd_data/rd_last  word output, rd_last marks last word
//   word_cnt, work_cnt     stored words (incl. partial) / complete works
//   empty, full            occupancy flags
//   irq                    registered level interrupt
//   last_id                work ID of the most recently popped work
module bm13xx_work_tx_buf
    import bm13xx_pkg::*;
#(
    parameter int DEPTH         = 512,
    parameter int MAX_MIDSTATES = 4,
    parameter int WORK_ID_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_clr,
    input  logic [1:0]                 midstate_cfg,
    input  logic                       irq_en,
    input  logic [$clog2(DEPTH):0]     irq_thr,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [31:0]                wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [31:0]                rd_data,
    output logic                       rd_last,
    output logic [$clog2(DEPTH):0]     word_cnt,
    output logic [$clog2(DEPTH):0]     work_cnt,
    output logic                       empty,
    output logic                       full,
    output logic                       irq,
    output logic [WORK_ID_W-1:0]       last_id
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_last;
    logic                  fetch;
    logic [WORK_LEN_W-1:0] wr_idx;
    logic [WORK_LEN_W-1:0] cur_len;
    logic [WORK_LEN_W-1:0] len_now;
    // Words in the RAM that belong to complete works; only these may be
    // moved to the output register, which is what makes the buffer
    // store-and-forward. Since complete works always precede the partial
    // one, a non-zero count guarantees the RAM head is releasable.
    logic [CW-1:0]         ready_words;
    logic                  rd_first;
    logic [32:0]           fifo_out;

    assign full     = (word_cnt == CW'(DEPTH));
    assign empty    = (word_cnt == '0);
    assign wr_ready = !full;

    assign wr_fire  = wr_valid && wr_ready && !fifo_clr;
    assign rd_fire  = rd_valid && rd_ready && !fifo_clr;

    // Length is taken live on word 0 and frozen for the rest of the work.
    assign len_now  = (wr_idx == '0)
                      ? work_len(midstate_code_t'(midstate_cfg), MAX_MIDSTATES)
                      : cur_len;
    assign wr_last  = (wr_idx == len_now - WORK_LEN_W'(1));

    assign rd_data  = fifo_out[31:0];
    assign rd_last  = fifo_out[32];

    bm13xx_sync_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (fifo_clr),
        .wr_en    (wr_fire),
        .wr_data  ({wr_last, wr_data}),
        .fetch_en (ready_words != '0),
        .fetch    (fetch),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (fifo_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx      <= '0;
            cur_len     <= '0;
            word_cnt    <= '0;
            work_cnt    <= '0;
            ready_words <= '0;
            rd_first    <= 1'b1;
            last_id     <= '0;
        end else if (fifo_clr) begin
            wr_idx      <= '0;
            word_cnt    <= '0;
            work_cnt    <= '0;
            ready_words <= '0;
            rd_first    <= 1'b1;
        end else begin
            if (wr_fire) begin
                if (wr_idx == '0) cur_len <= len_now;
                wr_idx <= wr_last ? '0 : wr_idx + WORK_LEN_W'(1);
            end
            word_cnt    <= word_cnt + CW'(wr_fire) - CW'(rd_fire);
            work_cnt    <= work_cnt + CW'(wr_fire && wr_last) - CW'(rd_fire && rd_last);
            ready_words <= ready_words + ((wr_fire && wr_last) ? CW'(len_now) : '0)
                           - CW'(fetch);
            if (rd_fire) begin
                if (rd_first) last_id <= rd_data[WORK_ID_W-1:0];
                rd_first <= rd_last;
            end
        end
    end

    // Evaluated every cycle from the registered word count, flush included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= irq_en && ((CW'(DEPTH) - word_cnt) >= irq_thr);
    end

endmodule

// File: tb/tb_bm13xx_work_tx_buf.sv
module tb_bm13xx_work_tx_buf;

    localparam int DEPTH = 512;
    localparam int MAXM  = 4;
    localparam int IDW   = 16;
    localparam int CW    = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fifo_clr = 1'b0;
    logic [1:0]      midstate_cfg = 2'd0;
    logic            irq_en = 1'b0;
    logic [CW-1:0]   irq_thr = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [31:0]     wr_data = '0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [31:0]     rd_data;
    logic            rd_last;
    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   work_cnt;
    logic            empty;
    logic            full;
    logic            irq;
    logic [IDW-1:0]  last_id;

    bm13xx_work_tx_buf #(
        .DEPTH         (DEPTH),
        .MAX_MIDSTATES (MAXM),
        .WORK_ID_W     (IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_clr     (fifo_clr),
        .midstate_cfg (midstate_cfg),
        .irq_en       (irq_en),
        .irq_thr      (irq_thr),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .word_cnt     (word_cnt),
        .work_cnt     (work_cnt),
        .empty        (empty),
        .full         (full),
        .irq          (irq),
        .last_id      (last_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: a queue of {last, data} for every stored word.
    logic [32:0]    mq[$];
    int             m_works;
    int             m_idx;
    int             m_len;
    bit             m_irq;
    bit             m_first;
    logic [IDW-1:0] m_last_id;

    int wr_fires = 0;
    int pops = 0;
    int last_wr_cyc = -1;
    int rv_rise_cyc = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc = -1;
    bit prev_rv = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int len_of(input logic [1:0] c);
        int m;
        m = (c == 2'd1) ? 2 : (c == 2'd2) ? 4 : 1;
        if (m > MAXM) m = MAXM;
        return 4 + 8 * m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_works   = 0;
        m_idx     = 0;
        m_len     = 0;
        m_irq     = 1'b0;
        m_first   = 1'b1;
        m_last_id = '0;
        prev_rv   = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 1);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_last"},  rd_last, 0);
        check({tag, "_rd_data"},  rd_data, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
        check({tag, "_work_cnt"}, work_cnt, 0);
        check({tag, "_empty"},    empty, 1);
        check({tag, "_full"},     full, 0);
        check({tag, "_irq"},      irq, 0);
        check({tag, "_last_id"},  last_id, 0);
    endtask

    // One clock: check registered outputs against the model at the falling
    // edge, apply this cycle's handshakes to the model, then move past the
    // rising edge.
    task automatic step();
        bit          wf;
        bit          rf;
        bit          nxt_irq;
        logic [32:0] w;
        @(negedge clk);
        cyc++;
        check("word_cnt", word_cnt, mq.size());
        check("work_cnt", work_cnt, m_works);
        check("empty",    empty, mq.size() == 0);
        check("full",     full, mq.size() == DEPTH);
        check("wr_ready", wr_ready, mq.size() != DEPTH);
        check("irq",      irq, m_irq);
        check("last_id",  last_id, m_last_id);
        if (m_works == 0) check("rd_valid_gate", rd_valid, 0);
        if (rd_valid === 1'b1 && !prev_rv) rv_rise_cyc = cyc;
        prev_rv = (rd_valid === 1'b1);
        wf = (wr_valid && wr_ready && !fifo_clr) === 1'b1;
        rf = (rd_valid && rd_ready && !fifo_clr) === 1'b1;
        nxt_irq = irq_en && ((DEPTH - mq.size()) >= int'(irq_thr));
        if (fifo_clr) begin
            mq.delete();
            m_works = 0;
            m_idx   = 0;
            m_first = 1'b1;
        end else begin
            if (rf) begin
                w = (mq.size() != 0) ? mq.pop_front() : 'x;
                check("rd_data", rd_data, w[31:0]);
                check("rd_last", rd_last, w[32]);
                if (m_first) m_last_id = w[IDW-1:0];
                m_first = (w[32] === 1'b1);
                if (w[32] === 1'b1) m_works--;
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            if (wf) begin
                if (m_idx == 0) m_len = len_of(midstate_cfg);
                w = {m_idx == m_len - 1, wr_data};
                mq.push_back(w);
                wr_fires++;
                if (w[32]) begin
                    m_works++;
                    m_idx = 0;
                    last_wr_cyc = cyc;
                end else begin
                    m_idx++;
                end
            end
        end
        m_irq = nxt_irq;
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n, input logic [1:0] cfg, input logic [31:0] id);
        int target;
        int start;
        int guard;
        start  = wr_fires;
        target = wr_fires + n;
        guard  = 0;
        midstate_cfg = cfg;
        while (wr_fires < target && guard < n + 2000) begin
            wr_valid = 1'b1;
            wr_data  = (wr_fires == start) ? id : $urandom;
            step();
            guard++;
        end
        wr_valid = 1'b0;
        check("write_done", wr_fires, target);
    endtask

    task automatic drain_until(input int works_left, input int budget);
        int g;
        g = 0;
        rd_ready = 1'b1;
        while (m_works > works_left && g < budget) begin
            step();
            g++;
        end
        rd_ready = 1'b0;
        check("drain_done", work_cnt, works_left);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [IDW-1:0] saved_id;

        model_reset();
        #12;
        reset_checks("rst0");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 12-word work: latency, framing, last_id.
        rv_rise_cyc = -1;
        write_words(12, 2'd0, 32'h0000_00A5);
        idle(3);
        check("lat12", rv_rise_cyc - last_wr_cyc, 2);
        check("work_cnt_1", work_cnt, 1);
        drain_until(0, 100);
        check("last_id_A5", last_id, 16'h00A5);

        // cfg changes mid-work: one 36-word work, held until complete.
        rv_rise_cyc = -1;
        write_words(11, 2'd2, 32'hCAFE_1234);
        midstate_cfg = 2'd0;
        write_words(25, 2'd0, $urandom);
        idle(3);
        check("lat36", rv_rise_cyc - last_wr_cyc, 2);
        p0 = pops;
        drain_until(0, 100);
        check("work36_words", pops - p0, 36);
        check("last_id_1234", last_id, 16'h1234);

        // Fill to DEPTH with 20-word works, then drain with no bubbles.
        write_words(DEPTH, 2'd1, 32'h0000_0BEE);
        idle(1);
        check("fill_full", full, 1);
        check("fill_wr_ready", wr_ready, 0);
        check("fill_works", work_cnt, 25);
        wr_valid = 1'b1;
        idle(3);
        wr_valid = 1'b0;
        p0 = pops;
        first_pop_cyc = -1;
        drain_until(0, 1000);
        check("drain_pops", pops - p0, 500);
        check("no_bubble", last_pop_cyc - first_pop_cyc + 1, 500);
        idle(2);
        check("partial_words", word_cnt, 12);
        check("partial_rv", rd_valid, 0);

        // IRQ threshold crossing at 412 -> 413 words.
        irq_thr = 10'd100;
        irq_en  = 1'b1;
        write_words(400, 2'd1, $urandom);
        idle(2);
        check("irq_412", irq, 1);
        write_words(1, 2'd1, $urandom);
        check("irq_hold", irq, 1);
        idle(1);
        check("irq_413", irq, 0);
        write_words(0, 2'd1, 0);
        irq_en  = 1'b0;
        irq_thr = 10'd0;
        idle(4);
        check("irq_dis", irq, 0);

        // Flush with same-cycle write and pop, two works plus a partial.
        fifo_clr = 1'b1;
        idle(1);
        fifo_clr = 1'b0;
        write_words(12, 2'd0, 32'h0000_0B01);
        write_words(12, 2'd0, 32'h0000_0B02);
        write_words(5, 2'd0, 32'h0000_0B03);
        idle(3);
        check("pre_clr_rv", rd_valid, 1);
        saved_id = m_last_id;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        fifo_clr = 1'b1;
        idle(1);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        fifo_clr = 1'b0;
        check("clr_words", word_cnt, 0);
        check("clr_works", work_cnt, 0);
        check("clr_empty", empty, 1);
        check("clr_rv", rd_valid, 0);
        check("clr_last_id", last_id, saved_id);
        write_words(12, 2'd0, 32'h0000_0B04);
        idle(3);
        drain_until(0, 100);
        check("post_clr_id", last_id, 16'h0B04);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_valid     = ($urandom_range(0, 3) != 0);
            wr_data      = $urandom;
            rd_ready     = ($urandom_range(0, 2) != 0);
            midstate_cfg = 2'($urandom_range(0, 3));
            fifo_clr     = ($urandom_range(0, 299) == 0);
            if (i % 50 == 0) begin
                irq_en  = $urandom_range(0, 1) != 0;
                irq_thr = CW'($urandom_range(0, DEPTH));
            end
            step();
        end
        wr_valid = 1'b0;
        fifo_clr = 1'b0;
        irq_en   = 1'b0;
        drain_until(0, 1000);

        // Reset in the middle of popping a work.
        fifo_clr = 1'b1;
        idle(1);
        fifo_clr = 1'b0;
        write_words(12, 2'd0, 32'h0000_0C0C);
        idle(3);
        rd_ready = 1'b1;
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("rst_mid");
        model_reset();
        rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        write_words(12, 2'd0, 32'h0000_0D0D);
        idle(3);
        drain_until(0, 100);
        check("post_rst_id", last_id, 16'h0D0D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bm13xx_work_tx_buf.md
# bm13xx_work_tx_buf

Parametrised work-transmit buffer for the BM13xx AXI IP core. It replaces the fixed work TX FIFO with a store-and-forward buffer that frames 32-bit words into work records. Each record's length is derived from the midstate mode (1/2/4 midstates) sampled per work. It also tracks word and work occupancy, raises a free-space threshold IRQ and captures the last dispatched work ID. It sits between the AXI register slave (WORK_TX_FIFO writes) and the work serialiser toward the chip chain.

## Interface
- DEPTH, 512: buffer depth in 32-bit words; power of two, ≥ 64.
- MAX_MIDSTATES, 4: largest supported midstate count; 1, 2 or 4.
- WORK_ID_W, 16: width of the work ID carried in word 0, bits [WORK_ID_W-1:0].
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_clr  in  1  synchronous flush pulse (CTRL_RST_TX_FIFO).
- midstate_cfg  in  2  midstate code: 0→1, 1→2, 2→4; 3 reserved, treated as 1.
- irq_en  in  1  IRQ enable.
- irq_thr  in  $clog2(DEPTH)+1  free-space threshold in words.
- wr_valid / wr_ready  in/out  1  write handshake.
- wr_data  in  32  work word.
- rd_valid / rd_ready  out/in  1  read handshake.
- rd_data  out  32  work word.
- rd_last  out  1  last word of the work.
- word_cnt  out  $clog2(DEPTH)+1  words stored, including any partial work.
- work_cnt  out  $clog2(DEPTH)+1  complete works stored.
- empty, full  out  1  word_cnt==0, word_cnt==DEPTH.
- irq  out  1  level interrupt.
- last_id  out  WORK_ID_W  ID of the most recently popped work.

## Operation
- Work length: L = 4 + 8·M words, giving 12/20/36.
  - midstate_cfg is sampled only on the write of word 0 of each work and held until that work's last word.
  - A code exceeding MAX_MIDSTATES clamps to MAX_MIDSTATES.
- Write side:
  - A word is accepted on wr_valid && wr_ready; wr_ready = !full.
  - A write word counter runs 0..L-1. Word L-1 is stored with last flag=1; FIFO entries are 33 bits wide.
- Read side is store-and-forward: rd_valid only while work_cnt>0, or while the output register holds a word of a work already in flight.
  - Words leave in order; rd_last is taken from the stored flag.
  - work_cnt decrements on the pop of a word with rd_last=1.
- last_id updates from rd_data[WORK_ID_W-1:0] on the pop of each work's word 0.
- IRQ: irq = irq_en && (DEPTH − word_cnt) ≥ irq_thr. It is registered and re-evaluated every cycle.
- fifo_clr performs the following in one cycle:
  - zero pointers, word_cnt and work_cnt;
  - discard any partial work and reset the write word counter;
  - drop the output register.
  - last_id is kept.
  - fifo_clr has priority over a same-cycle write or read, both of which are ignored.
- Simultaneous completion of one work and pop-completion of another leaves work_cnt unchanged. Same-cycle push and pop leave word_cnt unchanged.
- A partial work at full blocks writes. It never deadlocks reads, because complete works ahead of it still drain.

## Timing
- Reset values:
  - wr_ready=1, rd_valid=0, rd_last=0, rd_data=0;
  - word_cnt=0, work_cnt=0, empty=1, full=0;
  - irq=0, last_id=0.
- Counters, full, empty and work_cnt update on the cycle after the handshake (registered).
- Latency: the handshake of a work's last word at cycle N → rd_valid=1 at N+2, given an empty output register.
- Read throughput: one word per cycle while rd_ready=1 and the data is complete. There is no bubble between consecutive works.
- rd_data, rd_last and rd_valid are stable while rd_valid && !rd_ready.
- irq asserts/deasserts one cycle after the word_cnt or irq_thr change that crosses the threshold.

## Structure
- Shared package bm13xx_pkg holds:
  - the midstate code typedef;
  - WORK_HDR_WORDS=4 and MIDSTATE_WORDS=8;
  - function work_len(code, max).
- Sub-module bm13xx_sync_fifo: generic show-ahead single-clock FIFO (WIDTH, DEPTH) with a registered RAM read and an output register.
- The framing, counters, IRQ and last_id logic live in the top module.

## Test plan
- midstate_cfg=0, write 12 words with ID 0x00A5 → rd_valid at N+2; 12 words out with rd_last only on word 11; work_cnt 1→0; last_id=0x00A5.
- Write 11 words with cfg=2, then change cfg to 0 and write 25 more → one 36-word work; rd_valid never asserted before word 35 is written.
- Fill DEPTH=512 with cfg=1 (25 works of 20 words plus 12 words) → full=1, wr_ready=0, work_cnt=25; drain all 25 works → word_cnt=12, rd_valid=0.
- irq_thr=100, irq_en=1: word_cnt 412→413 → irq falls one cycle later; with irq_en=0 → irq=0 throughout.
- fifo_clr in the same cycle as a write and a pop with 2 works plus a partial work stored → next cycle word_cnt=0, work_cnt=0, empty=1; last_id unchanged.
- Assert rst_n low mid-pop → all outputs immediately at their reset values; the next write starts a fresh work at word 0.
